// File: rtl/handshake_pkg.sv
// Shared definitions for the two-clock level handshake (receiver side).
// Holds the receive FSM encoding and the default widths/depths.
package handshake_pkg;

  localparam int unsigned DEFAULT_DATA_BITS   = 32;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_DELIVER = 2'd1,
    RX_ACK     = 2'd2
  } rx_state_t;

endpackage

// File: rtl/receiver_if.sv
// Bundle of the receiver's handshake, delivery and status signals.
// The master modport is the receiver itself; slave is its surroundings.
interface receiver_if
  import handshake_pkg::*;
#(
  parameter int unsigned data_bits = DEFAULT_DATA_BITS
);

  logic                 req_tx;
  logic [data_bits-1:0] data_tx;
  logic                 ack_rx;
  logic [data_bits-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 req_synced;
  logic                 proto_err;

  modport master (
    input  req_tx, data_tx, data_ready,
    output ack_rx, data_out, data_valid, req_synced, proto_err
  );

  modport slave (
    output req_tx, data_tx, data_ready,
    input  ack_rx, data_out, data_valid, req_synced, proto_err
  );

endinterface

// File: rtl/sync_ff_chain.sv
// Single-bit reset-to-0 synchronizer: a plain chain of `stages` flops.
// The output is the last flop, so it is always a registered signal.
module sync_ff_chain #(
  parameter int unsigned stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [stages-1:0] ff;

  // NOTE: non-blocking assignments make every flop sample the previous
  // stage's old value, which is what turns this into a shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[stages-2:0], d};
    end
  end

  assign q = ff[stages-1];

endmodule

// File: rtl/receiver.sv
// Destination end of the 4-phase level handshake: synchronizes req_tx,
// captures data_tx, hands it over valid/ready, then raises ack until req drops.
module receiver
  import handshake_pkg::*;
#(
  parameter int unsigned data_bits   = DEFAULT_DATA_BITS,
  parameter int unsigned sync_stages = DEFAULT_SYNC_STAGES
) (
  input logic       clk,
  input logic       rst,
  receiver_if.master bus
);

  rx_state_t            state;
  logic                 req_s;
  logic                 ack_q;
  logic                 valid_q;
  logic                 err_q;
  logic [data_bits-1:0] data_q;

  sync_ff_chain #(
    .stages (sync_stages)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.req_tx),
    .q   (req_s)
  );

  // data_tx is captured without a synchronizer: it is only sampled once
  // req_s is high, and the sender holds it stable until ack comes back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RX_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (req_s) begin
            data_q  <= bus.data_tx;
            valid_q <= 1'b1;
            state   <= RX_DELIVER;
          end
        end
        RX_DELIVER: begin
          // Request withdrawn before ack: flag it, but still finish delivery.
          if (!req_s) begin
            err_q <= 1'b1;
          end
          if (valid_q && bus.data_ready) begin
            valid_q <= 1'b0;
            ack_q   <= 1'b1;
            state   <= RX_ACK;
          end
        end
        RX_ACK: begin
          if (!req_s) begin
            ack_q <= 1'b0;
            state <= RX_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          valid_q <= 1'b0;
          state   <= RX_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_rx     = ack_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.req_synced = req_s;
  assign bus.proto_err  = err_q;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: two builds (2 and 3 sync stages) share clk/rst;
// a behavioural transmitter on a slower clock drives the back-to-back case.
module tb_receiver;

  logic clk  = 1'b0;
  logic tclk = 1'b0;
  logic rst  = 1'b1;

  always #3 clk  = ~clk;   // 6 ns receive clock
  always #7 tclk = ~tclk;  // 14 ns transmit clock (3:7)

  receiver_if #(.data_bits(32)) bus2 ();
  receiver_if #(.data_bits(32)) bus3 ();

  receiver #(.data_bits(32), .sync_stages(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  receiver #(.data_bits(32), .sync_stages(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.master)
  );

  int total = 0;
  int bad   = 0;
  int tx_timeouts = 0;
  bit mon_en = 1'b0;
  logic [31:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Records every accepted word of the 2-stage build.
  always @(negedge clk) begin
    if (mon_en && bus2.data_valid && bus2.data_ready)
      got_q.push_back(bus2.data_out);
  end

  // Behavioural transmitter: 2-flop ack synchronizer in the tclk domain.
  task automatic tx_word(input logic [31:0] w);
    logic s1, s2;
    int   n;
    s1 = 1'b0;
    s2 = 1'b0;
    @(posedge tclk); #1;
    bus2.data_tx = w;
    @(posedge tclk); #1;
    bus2.req_tx = 1'b1;
    n = 0;
    while (!s2 && n < 100) begin
      @(posedge tclk);
      s2 = s1;
      s1 = bus2.ack_rx;
      n++;
    end
    if (!s2) tx_timeouts++;
    #1;
    bus2.req_tx = 1'b0;
    n = 0;
    while (s2 && n < 100) begin
      @(posedge tclk);
      s2 = s1;
      s1 = bus2.ack_rx;
      n++;
    end
    if (s2) tx_timeouts++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus2.req_tx = 1'b0; bus2.data_tx = '0; bus2.data_ready = 1'b0;
    bus3.req_tx = 1'b0; bus3.data_tx = '0; bus3.data_ready = 1'b0;

    // Reset state
    tick(3);
    check("rst_ack",   bus2.ack_rx,     0);
    check("rst_valid", bus2.data_valid, 0);
    check("rst_data",  bus2.data_out,   0);
    check("rst_err",   bus2.proto_err,  0);
    check("rst_sync",  bus2.req_synced, 0);
    rst = 1'b0;
    tick(2);

    // Single transfer, ready high
    bus2.data_tx = 32'hDEAD_BEEF; bus2.req_tx = 1'b1; bus2.data_ready = 1'b1;
    tick(1);
    check("t1_sync_k",   bus2.req_synced, 0);
    tick(1);
    check("t1_sync_k1",  bus2.req_synced, 1);
    check("t1_valid_k1", bus2.data_valid, 0);
    tick(1);
    check("t1_valid_k2", bus2.data_valid, 1);
    check("t1_data",     bus2.data_out,   32'hDEAD_BEEF);
    check("t1_ack_k2",   bus2.ack_rx,     0);
    tick(1);
    check("t1_ack_up",   bus2.ack_rx,     1);
    check("t1_valid_dn", bus2.data_valid, 0);
    bus2.req_tx = 1'b0;
    tick(2);
    check("t1_ack_m1",   bus2.ack_rx,     1);
    check("t1_sync_dn",  bus2.req_synced, 0);
    tick(1);
    check("t1_ack_m2",   bus2.ack_rx,     0);
    check("t1_err",      bus2.proto_err,  0);

    // Backpressure
    bus2.data_ready = 1'b0; bus2.data_tx = 32'hA5A5_0F0F; bus2.req_tx = 1'b1;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", bus2.data_valid, 1);
      check("bp_data",  bus2.data_out,   32'hA5A5_0F0F);
      check("bp_ack",   bus2.ack_rx,     0);
      tick(1);
    end
    bus2.data_ready = 1'b1;
    tick(1);
    check("bp_ack_up",   bus2.ack_rx,     1);
    check("bp_valid_dn", bus2.data_valid, 0);
    bus2.req_tx = 1'b0;
    tick(3);
    check("bp_ack_dn",   bus2.ack_rx,     0);
    check("bp_data_hold", bus2.data_out,  32'hA5A5_0F0F);

    // Back-to-back words from a transmitter on an unrelated clock
    bus2.data_ready = 1'b1;
    mon_en = 1'b1;
    tx_word(32'h1);
    tx_word(32'h2);
    tx_word(32'h3);
    tick(10);
    mon_en = 1'b0;
    check("b2b_timeout", tx_timeouts, 0);
    check("b2b_count",   32'(got_q.size()), 3);
    for (int i = 0; i < 3; i++)
      check("b2b_word", got_q[i], 32'(i + 1));
    check("b2b_err",     bus2.proto_err, 0);
    tick(2);

    // Premature request withdrawal while delivering
    bus2.data_ready = 1'b0; bus2.data_tx = 32'hCAFE_F00D; bus2.req_tx = 1'b1;
    tick(3);
    check("pe_valid", bus2.data_valid, 1);
    bus2.req_tx = 1'b0;
    tick(2);
    check("pe_err_early", bus2.proto_err, 0);
    tick(1);
    check("pe_err_set",   bus2.proto_err,  1);
    check("pe_valid_hold", bus2.data_valid, 1);
    check("pe_data",      bus2.data_out,   32'hCAFE_F00D);
    bus2.data_ready = 1'b1;
    tick(1);
    check("pe_ack_pulse", bus2.ack_rx,     1);
    check("pe_valid_dn",  bus2.data_valid, 0);
    tick(1);
    check("pe_ack_end",   bus2.ack_rx,     0);
    tick(3);
    check("pe_err_sticky", bus2.proto_err, 1);
    check("pe_idle_valid", bus2.data_valid, 0);

    // Reset in RX_ACK with req still high
    bus2.data_tx = 32'h1234_5678; bus2.req_tx = 1'b1;
    tick(4);
    check("rr_ack_pre", bus2.ack_rx, 1);
    rst = 1'b1;
    #1;
    check("rr_ack",   bus2.ack_rx,     0);
    check("rr_valid", bus2.data_valid, 0);
    check("rr_data",  bus2.data_out,   0);
    check("rr_err",   bus2.proto_err,  0);
    check("rr_sync",  bus2.req_synced, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check("rr_valid_early", bus2.data_valid, 0);
    tick(1);
    check("rr_valid_again", bus2.data_valid, 1);
    check("rr_data_again",  bus2.data_out,   32'h1234_5678);
    tick(1);
    check("rr_ack_up", bus2.ack_rx, 1);
    bus2.req_tx = 1'b0;
    tick(3);
    check("rr_ack_dn", bus2.ack_rx, 0);

    // Three-stage build: every sync latency grows by one
    bus3.data_tx = 32'h0BAD_F00D; bus3.req_tx = 1'b1; bus3.data_ready = 1'b1;
    tick(2);
    check("s3_sync_k1",  bus3.req_synced, 0);
    tick(1);
    check("s3_sync_k2",  bus3.req_synced, 1);
    check("s3_valid_k2", bus3.data_valid, 0);
    tick(1);
    check("s3_valid_k3", bus3.data_valid, 1);
    check("s3_data",     bus3.data_out,   32'h0BAD_F00D);
    tick(1);
    check("s3_ack_up",   bus3.ack_rx,     1);
    bus3.req_tx = 1'b0;
    tick(3);
    check("s3_ack_m2",   bus3.ack_rx,     1);
    tick(1);
    check("s3_ack_m3",   bus3.ack_rx,     0);
    check("s3_err",      bus3.proto_err,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
